nand_core_w: RTL
================

# nand_core_w

Parametrised successor to the one-bit NAND processor: a single-issue NAND/branch machine with DATA_W-bit registers and bitwise NAND. Programs arrive through a serial, handshaked loader that replaces the old enable-edge loading scheme. Explicit LOAD/RUN/HALT control is added, with optional halt detection. It sits between the board-level input pins and the output register bank, exactly where the one-bit core sits today.

## Interface
- DATA_W, 4: register and NAND width in bits.
- ADDR_W, 4: register address width; INSTR_W = 1+3*ADDR_W; branch offset width OFF_W = 2*ADDR_W-1.
- IMEM_DEPTH, 1000: instruction words stored.
- PC_W, 10: program counter width; 2**PC_W >= IMEM_DEPTH.
- NUM_IN, 2 / NUM_OUT, 7 / NUM_INT, 6: input, output and internal register counts; 1+NUM_IN+NUM_OUT+NUM_INT <= 2**ADDR_W.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run_en  in  1  execute one instruction per cycle in RUN when high; stall when low.
- in_regs  in  NUM_IN*DATA_W  input registers, sampled combinationally.
- out_regs  out  NUM_OUT*DATA_W  output registers; reset 0.
- prog_start  in  1  pulse: abandon RUN/HALT, enter LOAD.
- prog_valid / prog_bit / prog_last  in  1 each  serial program bit, LSB of each word first; prog_last marks the final bit.
- prog_ready  out  1  high in LOAD; reset 1.
- prog_err  out  1  sticky: program overflowed IMEM_DEPTH; reset 0, cleared on prog_start.
- pc  out  PC_W  current PC; reset 0.
- halted  out  1  high in HALT; reset 0.

## Operation
- Register map: addr 0 is the all-ones constant. Addrs 1..NUM_IN are inputs. The next NUM_OUT addrs are outputs, then the next NUM_INT addrs are internal registers. Unmapped reads return 0. Writes to constant, input or unmapped addresses are ignored.
- NAND instruction (bit0 = 1): ra=[ADDR_W:1], rb=[2*ADDR_W:ADDR_W+1], rd=[3*ADDR_W:2*ADDR_W+1].
  - reg[rd] <= ~(reg[ra] & reg[rb]).
  - pc <= pc+1.
- Branch instruction (bit0 = 0): ra=[ADDR_W:1], dir=[ADDR_W+1], off=[INSTR_W-1:ADDR_W+2].
  - Taken iff reg[ra][0] = 1; then pc <= dir ? pc-off : pc+off.
  - Not taken: pc <= pc+1.
- PC arithmetic is modulo 2**PC_W. A fetch at pc >= loaded word count returns all-zero. All-zero decodes as a taken branch on constant with offset 0.
- States:
  - LOAD: reset state. Each prog_valid&prog_ready cycle stores prog_bit at bit_cnt of word word_cnt.
    - bit_cnt wraps at INSTR_W, and word_cnt then increments.
    - prog_last accepted: a partial word is zero-padded and counted. Then word count is recorded, pc <= 0, and the state goes to RUN.
    - Bits beyond IMEM_DEPTH words are dropped and set prog_err; acceptance continues until prog_last.
  - RUN: one instruction per cycle while run_en is high.
  - HALT: entered per Configuration. pc and registers are frozen.
  - prog_start in RUN or HALT goes to LOAD and clears bit_cnt, word_cnt and prog_err. Registers keep their values. Instruction memory is not cleared.
- Reset clears PC, counters, word count, out_regs, internal regs, prog_err and state to LOAD. Instruction memory is not reset; it is unreadable until reloaded because the word count is 0.

## Timing
- Single-cycle execution: read combinational, write at the rising edge. The next instruction sees the written value.
- Back-to-back NANDs on the same rd: the second reads the first's result.
- The first instruction executes in the cycle after the prog_last handshake.
- prog_start takes priority over execution in the same cycle; no instruction retires that cycle.
- prog_start during LOAD restarts loading at word 0, bit 0. A bit presented in that same cycle is ignored.
- run_en low: pc, registers and state are held. run_en has no effect in LOAD or HALT.
- Reset asserted mid-load or mid-run: all outputs go to reset values immediately (asynchronous).

## Configuration
- NAND_CORE_HALT_EN defined:
  - A taken branch with off = 0 enters HALT at the next edge, and halted goes to 1.
  - Running past the loaded program therefore halts.
- NAND_CORE_HALT_EN undefined:
  - Such a branch self-loops in RUN indefinitely.
  - halted is tied 0 and the HALT state is not built.

## Test plan
- Reset then load a 1-word NAND program (rd = out0, ra = rb = const), DATA_W = 4 -> out_regs[3:0] = 4'h0 after one RUN cycle, with pc = 1.
- Load NAND(out0 <= ~(in0 & const)) with in0 = 4'h5, followed by a branch-back of off = 1 -> out0 = 4'hA every cycle; pc alternates 0/1.
- Conditional branch with dir = 1, off = 3, at pc = 5 with reg[ra][0] = 1 -> pc = 2. With reg[ra][0] = 0 -> pc = 6.
- With HALT_EN, run off the end of a 2-word program -> halted = 1 at pc = 2, frozen. Without HALT_EN -> pc stays at 2, halted = 0.
- Load IMEM_DEPTH+1 words -> prog_err = 1, RUN entered. A subsequent prog_start clears prog_err to 0.
- Assert reset mid-load (word 3, bit 7) -> prog_ready = 1, pc = 0, out_regs = 0. A reload from word 0 succeeds.

Source files
------------

// File: rtl/nand_core_w_if.sv
`default_nettype none
// ============================================================================
// Module   : nand_core_w_if
// Purpose  : Run control, register I/O and serial program-loader bundle for nand_core_w.
// Revision : 1.0 - initial release
// ============================================================================
interface nand_core_w_if #(
    parameter int DATA_W  = 4,
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 7,
    parameter int PC_W    = 10
);
    logic                      run_en;
    logic [NUM_IN*DATA_W-1:0]  in_regs;
    logic [NUM_OUT*DATA_W-1:0] out_regs;
    logic                      prog_start;
    logic                      prog_valid;
    logic                      prog_bit;
    logic                      prog_last;
    logic                      prog_ready;
    logic                      prog_err;
    logic [PC_W-1:0]           pc;
    logic                      halted;

    modport master (
        output run_en, in_regs, prog_start, prog_valid, prog_bit, prog_last,
        input  out_regs, prog_ready, prog_err, pc, halted
    );

    modport slave (
        input  run_en, in_regs, prog_start, prog_valid, prog_bit, prog_last,
        output out_regs, prog_ready, prog_err, pc, halted
    );
endinterface
`default_nettype wire

// File: rtl/nand_core_w.sv
`default_nettype none
// ============================================================================
// Module   : nand_core_w
// Purpose  : DATA_W-bit NAND/branch processor with a serial program loader.
//            Optional macro NAND_CORE_HALT_EN: a taken zero-offset branch halts.
// Revision : 1.0 - initial release
// ============================================================================
module nand_core_w #(
    parameter int DATA_W     = 4,
    parameter int ADDR_W     = 4,
    parameter int IMEM_DEPTH = 1000,
    parameter int PC_W       = 10,
    parameter int NUM_IN     = 2,
    parameter int NUM_OUT    = 7,
    parameter int NUM_INT    = 6
) (
    input  wire logic    clk,
    input  wire logic    reset,
    nand_core_w_if.slave bus
);
    localparam int INSTR_W = 1 + 3*ADDR_W;
    localparam int OFF_W   = 2*ADDR_W - 1;
    localparam int BCNT_W  = $clog2(INSTR_W);
    localparam int OUT_BASE = 1 + NUM_IN;
    localparam int INT_BASE = 1 + NUM_IN + NUM_OUT;
    localparam logic [PC_W:0]     C_DEPTH    = (PC_W+1)'(IMEM_DEPTH);
    localparam logic [BCNT_W-1:0] C_LAST_BIT = BCNT_W'(INSTR_W - 1);

`ifdef NAND_CORE_HALT_EN
    typedef enum logic [1:0] {S_LOAD = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_LOAD = 2'd0, S_RUN = 2'd1} state_t;
`endif

    state_t                          state_q, state_d;
    logic [PC_W-1:0]                 pc_q, pc_d;
    logic [BCNT_W-1:0]               bit_cnt_q, bit_cnt_d;
    logic [PC_W:0]                   word_cnt_q, word_cnt_d;
    logic [PC_W:0]                   nwords_q, nwords_d;
    logic                            err_q, err_d;
    logic [INSTR_W-1:0]              buf_q, buf_d;
    logic [NUM_OUT-1:0][DATA_W-1:0]  outr_q, outr_d;
    logic [NUM_INT-1:0][DATA_W-1:0]  intr_q, intr_d;
    logic                            prog_ready_q;
    logic [INSTR_W-1:0]              imem_q [0:IMEM_DEPTH-1];

    logic                            imem_we;
    logic [INSTR_W-1:0]              w_asm;
    logic                            w_room;
    logic [INSTR_W-1:0]              w_instr;
    logic [ADDR_W-1:0]               w_ra, w_rb, w_rd;
    logic                            w_dir;
    logic [OFF_W-1:0]                w_off;
    logic [PC_W-1:0]                 w_off_pc;
    logic [DATA_W-1:0]               w_va, w_vb, w_nand;

    function automatic logic [DATA_W-1:0] reg_read(
        input logic [ADDR_W-1:0]              a,
        input logic [NUM_IN*DATA_W-1:0]       inr,
        input logic [NUM_OUT-1:0][DATA_W-1:0] o,
        input logic [NUM_INT-1:0][DATA_W-1:0] n
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (a == '0) v = '1;
        for (int i = 0; i < NUM_IN; i++)
            if (a == ADDR_W'(1 + i)) v = inr[i*DATA_W +: DATA_W];
        for (int i = 0; i < NUM_OUT; i++)
            if (a == ADDR_W'(OUT_BASE + i)) v = o[i];
        for (int i = 0; i < NUM_INT; i++)
            if (a == ADDR_W'(INT_BASE + i)) v = n[i];
        return v;
    endfunction

    // Fetches past the loaded program read as zero: a taken branch-to-self on the constant.
    assign w_instr  = ({1'b0, pc_q} < nwords_q) ? imem_q[pc_q] : '0;
    assign w_ra     = w_instr[ADDR_W:1];
    assign w_rb     = w_instr[2*ADDR_W:ADDR_W+1];
    assign w_rd     = w_instr[3*ADDR_W:2*ADDR_W+1];
    assign w_dir    = w_instr[ADDR_W+1];
    assign w_off    = w_instr[INSTR_W-1:ADDR_W+2];
    assign w_off_pc = PC_W'(w_off);
    assign w_va     = reg_read(w_ra, bus.in_regs, outr_q, intr_q);
    assign w_vb     = reg_read(w_rb, bus.in_regs, outr_q, intr_q);
    assign w_nand   = ~(w_va & w_vb);
    assign w_asm    = buf_q | (INSTR_W'(bus.prog_bit) << bit_cnt_q);
    assign w_room   = (word_cnt_q < C_DEPTH);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        nwords_d   = nwords_q;
        err_d      = err_q;
        buf_d      = buf_q;
        outr_d     = outr_q;
        intr_d     = intr_q;
        imem_we    = 1'b0;
        if (bus.prog_start) begin
            state_d    = S_LOAD;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            err_d      = 1'b0;
            buf_d      = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (bus.prog_valid) begin
                        if (!w_room) err_d = 1'b1;
                        // A word closes on its last bit or on prog_last; unfilled bits stay zero.
                        if (bit_cnt_q == C_LAST_BIT || bus.prog_last) begin
                            imem_we   = w_room;
                            buf_d     = '0;
                            bit_cnt_d = '0;
                            if (w_room) word_cnt_d = word_cnt_q + 1'b1;
                        end else begin
                            buf_d     = w_asm;
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                        if (bus.prog_last) begin
                            nwords_d = w_room ? word_cnt_q + 1'b1 : word_cnt_q;
                            pc_d     = '0;
                            state_d  = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.run_en) begin
                        if (w_instr[0]) begin
                            for (int i = 0; i < NUM_OUT; i++)
                                if (w_rd == ADDR_W'(OUT_BASE + i)) outr_d[i] = w_nand;
                            for (int i = 0; i < NUM_INT; i++)
                                if (w_rd == ADDR_W'(INT_BASE + i)) intr_d[i] = w_nand;
                            pc_d = pc_q + 1'b1;
                        end else if (w_va[0]) begin
                            pc_d = w_dir ? pc_q - w_off_pc : pc_q + w_off_pc;
`ifdef NAND_CORE_HALT_EN
                            if (w_off == '0) state_d = S_HALT;
`endif
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_LOAD;
            pc_q         <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            nwords_q     <= '0;
            err_q        <= 1'b0;
            buf_q        <= '0;
            outr_q       <= '0;
            intr_q       <= '0;
            prog_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            nwords_q     <= nwords_d;
            err_q        <= err_d;
            buf_q        <= buf_d;
            outr_q       <= outr_d;
            intr_q       <= intr_d;
            prog_ready_q <= (state_d == S_LOAD);
        end
    end

    // Instruction memory is deliberately not reset; word count gates its visibility.
    always_ff @(posedge clk) begin
        if (imem_we) imem_q[word_cnt_q[PC_W-1:0]] <= w_asm;
    end

`ifdef NAND_CORE_HALT_EN
    logic halted_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) halted_q <= 1'b0;
        else       halted_q <= (state_d == S_HALT);
    end
    assign bus.halted = halted_q;
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.out_regs   = outr_q;
    assign bus.prog_ready = prog_ready_q;
    assign bus.prog_err   = err_q;
    assign bus.pc         = pc_q;
endmodule
`default_nettype wire
